// File: rtl/cpu_core.sv
// 16-bit multicycle CPU core: FETCH -> DECODE -> EXEC (-> WB for loads) with an external stall counter.
// Shares a dual-port memory with a sibling core; undefined opcodes halt the core until reset.
module cpu_core #(
    parameter int unsigned NREGS = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        halt,
    input  logic [16:0] pc_passed,
    input  logic [2:0]  stall_num,
    output logic [15:0] pc,
    input  logic [15:0] rdata0,
    output logic [15:0] raddr1,
    input  logic [16:0] rdata1,
    output logic        wen,
    output logic [14:0] waddr,
    output logic [15:0] wdata,
    output logic [2:0]  pauseResume,
    input  logic        debug
);

    localparam int unsigned XLEN = 16;
    localparam int unsigned RIDX = 4;
    localparam int unsigned SCW  = 3;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t              r_state;
    logic [XLEN-1:0]     r_pc;
    logic [XLEN-1:0]     r_regs [NREGS];
    logic [SCW-1:0]      r_stall_cnt;
    logic                r_halt;
    logic [XLEN-1:0]     r_raddr1;
    logic                r_wen;
    logic [14:0]         r_waddr;
    logic [XLEN-1:0]     r_wdata;
    logic [2:0]          r_pr;

    // Decoded instruction held from DECODE into EXEC/WB
    logic                r_wr_en;
    logic [RIDX-1:0]     r_wr_idx;
    logic [XLEN-1:0]     r_wr_val;
    logic                r_jmp;
    logic [XLEN-1:0]     r_jmp_tgt;
    logic                r_undef;
    logic                r_is_ld;

    logic [3:0]          w_op;
    logic [RIDX-1:0]     w_ra_idx;
    logic [RIDX-1:0]     w_rb_idx;
    logic [RIDX-1:0]     w_rt_idx;
    logic [7:0]          w_imm;
    logic [XLEN-1:0]     w_ra;
    logic [XLEN-1:0]     w_rb;
    logic [XLEN-1:0]     w_rt;
    logic                w_wr_en;
    logic [XLEN-1:0]     w_wr_val;
    logic                w_jmp;
    logic                w_ld;
    logic                w_st;
    logic                w_pr;
    logic                w_undef;
    logic                w_freeze;
    logic                w_unused;

    assign w_op     = rdata0[15:12];
    assign w_ra_idx = rdata0[11:8];
    assign w_rb_idx = rdata0[7:4];
    assign w_rt_idx = rdata0[3:0];
    assign w_imm    = rdata0[11:4];

    // Register 0 is hardwired to zero on every read port
    assign w_ra = (w_ra_idx == '0) ? '0 : r_regs[w_ra_idx];
    assign w_rb = (w_rb_idx == '0) ? '0 : r_regs[w_rb_idx];
    assign w_rt = (w_rt_idx == '0) ? '0 : r_regs[w_rt_idx];

    assign w_freeze = (r_state != S_HALTED) && ((r_stall_cnt != '0) || (stall_num != '0));
    assign w_unused = &{1'b0, debug, pc_passed[16], rdata1[16]};

    assign pc          = r_pc;
    assign halt        = r_halt;
    assign raddr1      = r_raddr1;
    assign wen         = r_wen;
    assign waddr       = r_waddr;
    assign wdata       = r_wdata;
    assign pauseResume = r_pr;

    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_val = '0;
        w_jmp    = 1'b0;
        w_ld     = 1'b0;
        w_st     = 1'b0;
        w_pr     = 1'b0;
        w_undef  = 1'b0;
        case (w_op)
            4'h0: begin
                w_wr_en  = 1'b1;
                w_wr_val = w_ra - w_rb;
            end
            4'h8: begin
                w_wr_en  = 1'b1;
                w_wr_val = {{8{w_imm[7]}}, w_imm};
            end
            4'h9: begin
                w_wr_en  = 1'b1;
                w_wr_val = {w_imm, w_rt[7:0]};
            end
            4'hD: w_pr = 1'b1;
            4'hE: begin
                case (w_rb_idx)
                    4'h0:    w_jmp   = (w_ra == '0);
                    4'h1:    w_jmp   = (w_ra != '0);
                    4'h2:    w_jmp   = w_ra[XLEN-1];
                    4'h3:    w_jmp   = !w_ra[XLEN-1];
                    default: w_undef = 1'b1;
                endcase
            end
            4'hF: begin
                case (w_rb_idx)
                    4'h0:    w_ld    = 1'b1;
                    4'h1:    w_st    = 1'b1;
                    default: w_undef = 1'b1;
                endcase
            end
            default: w_undef = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_FETCH;
            r_pc        <= pc_passed[XLEN-1:0];
            r_stall_cnt <= '0;
            r_halt      <= 1'b0;
            r_raddr1    <= '0;
            r_wen       <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_pr        <= '0;
            r_wr_en     <= 1'b0;
            r_wr_idx    <= '0;
            r_wr_val    <= '0;
            r_jmp       <= 1'b0;
            r_jmp_tgt   <= '0;
            r_undef     <= 1'b0;
            r_is_ld     <= 1'b0;
            for (int i = 0; i < int'(NREGS); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_freeze) begin
            // A running count takes priority; a fresh request covers this cycle plus stall_num-1 more
            r_stall_cnt <= (r_stall_cnt != '0) ? r_stall_cnt - SCW'(1) : stall_num - SCW'(1);
        end else begin
            case (r_state)
                S_FETCH: r_state <= S_DECODE;
                S_DECODE: begin
                    r_wr_en   <= w_wr_en;
                    r_wr_idx  <= w_rt_idx;
                    r_wr_val  <= w_wr_val;
                    r_jmp     <= w_jmp;
                    r_jmp_tgt <= w_rt;
                    r_undef   <= w_undef;
                    r_is_ld   <= w_ld;
                    r_halt    <= w_undef;
                    r_wen     <= w_st;
                    r_raddr1  <= w_ld ? {1'b1, w_ra[XLEN-1:1]} : '0;
                    r_pr      <= w_pr ? {1'b1, rdata0[1:0]} : '0;
                    if (w_st) begin
                        r_waddr <= w_ra[XLEN-1:1];
                        r_wdata <= w_rt;
                    end
                    r_state   <= S_EXEC;
                end
                S_EXEC: begin
                    r_wen <= 1'b0;
                    r_pr  <= '0;
                    if (r_undef) begin
                        r_state <= S_HALTED;
                    end else if (r_is_ld) begin
                        r_state <= S_WB;
                    end else begin
                        if (r_wr_en && (r_wr_idx != '0)) begin
                            r_regs[r_wr_idx] <= r_wr_val;
                        end
                        r_pc    <= r_jmp ? r_jmp_tgt : r_pc + XLEN'(2);
                        r_state <= S_FETCH;
                    end
                end
                S_WB: begin
                    if (r_wr_idx != '0) begin
                        r_regs[r_wr_idx] <= rdata1[XLEN-1:0];
                    end
                    r_raddr1 <= '0;
                    r_pc     <= r_pc + XLEN'(2);
                    r_state  <= S_FETCH;
                end
                default: begin
                    r_halt   <= 1'b1;
                    r_wen    <= 1'b0;
                    r_raddr1 <= '0;
                    r_pr     <= '0;
                    r_state  <= S_HALTED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Scoreboard bench for cpu_core: runs a small program from a behavioural dual-port memory and
// checks stores, load addresses, pause/resume pulses, stall freezing and halt against expectations.
module tb_cpu_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        halt;
    logic [16:0] pc_passed;
    logic [2:0]  stall_num;
    logic [15:0] pc;
    logic [15:0] rdata0;
    logic [15:0] raddr1;
    logic [16:0] rdata1;
    logic        wen;
    logic [14:0] waddr;
    logic [15:0] wdata;
    logic [2:0]  pauseResume;
    logic        debug;

    logic [15:0] mem [0:32767];
    logic [31:0] st_q [$];
    logic [15:0] rd_q [$];
    logic [2:0]  pr_q [$];

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] asm_pc;
    logic [15:0] p_addr, q_addr, h_addr;

    cpu_core #(.NREGS(16)) dut (
        .clk(clk), .reset(reset), .halt(halt), .pc_passed(pc_passed),
        .stall_num(stall_num), .pc(pc), .rdata0(rdata0), .raddr1(raddr1),
        .rdata1(rdata1), .wen(wen), .waddr(waddr), .wdata(wdata),
        .pauseResume(pauseResume), .debug(debug)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rdata0 <= mem[pc[15:1]];
        rdata1 <= {1'b0, mem[raddr1[14:0]]};
        if (wen) mem[waddr] <= wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] f_movl(input logic [3:0] t, input logic [7:0] i);
        return {4'h8, i, t};
    endfunction
    function automatic logic [15:0] f_movh(input logic [3:0] t, input logic [7:0] i);
        return {4'h9, i, t};
    endfunction
    function automatic logic [15:0] f_sub(input logic [3:0] a, input logic [3:0] b, input logic [3:0] t);
        return {4'h0, a, b, t};
    endfunction
    function automatic logic [15:0] f_jmp(input logic [3:0] a, input logic [3:0] c, input logic [3:0] t);
        return {4'hE, a, c, t};
    endfunction
    function automatic logic [15:0] f_ld(input logic [3:0] a, input logic [3:0] t);
        return {4'hF, a, 4'h0, t};
    endfunction
    function automatic logic [15:0] f_st(input logic [3:0] a, input logic [3:0] t);
        return {4'hF, a, 4'h1, t};
    endfunction

    task automatic emit(input logic [15:0] w);
        mem[asm_pc[15:1]] = w;
        asm_pc = asm_pc + 16'd2;
    endtask

    task automatic exp_st(input logic [14:0] wa, input logic [15:0] wd);
        st_q.push_back({1'b0, wa, wd});
    endtask

    // r9 walks the result area upward by 2 bytes (r10 = -2)
    task automatic bump_r9();
        emit(f_sub(4'd9, 4'd10, 4'd9));
    endtask

    task automatic wait_pc(input logic [15:0] a, input string tag);
        int k;
        k = 0;
        while (pc !== a && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(pc), 32'(a));
    endtask

    // Store scoreboard: one pop per write pulse, pulse must be a single cycle
    logic prev_wen = 1'b0;
    int   wen_len  = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (wen && !prev_wen) begin
                chk("store", {1'b0, waddr, wdata}, (st_q.size() != 0) ? st_q.pop_front() : 32'hDEAD_DEAD);
                wen_len = 1;
            end else if (wen) begin
                wen_len++;
            end else if (prev_wen) begin
                chk("store_len", 32'(wen_len), 32'd1);
            end
            prev_wen = wen;
        end
    end

    logic prev_rd = 1'b0;
    int   rd_len  = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (raddr1[15] && !prev_rd) begin
                chk("ld_raddr1", 32'(raddr1), (rd_q.size() != 0) ? 32'(rd_q.pop_front()) : 32'hDEAD_DEAD);
                rd_len = 1;
            end else if (raddr1[15]) begin
                rd_len++;
            end else if (prev_rd) begin
                chk("ld_len", 32'(rd_len), 32'd2);
            end
            prev_rd = raddr1[15];
        end
    end

    logic prev_pr = 1'b0;
    int   pr_len  = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (pauseResume != 3'b000 && !prev_pr) begin
                chk("pause_resume", 32'(pauseResume), (pr_q.size() != 0) ? 32'(pr_q.pop_front()) : 32'hDEAD_DEAD);
                pr_len = 1;
            end else if (pauseResume != 3'b000) begin
                pr_len++;
            end else if (prev_pr) begin
                chk("pr_len", 32'(pr_len), 32'd1);
            end
            prev_pr = (pauseResume != 3'b000);
        end
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: run did not complete, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   n;
        logic moved;
        logic bad;

        reset     = 1'b1;
        pc_passed = 17'h0_0200;
        stall_num = 3'd0;
        debug     = 1'b0;
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        mem[8] = 16'hBEEF;

        asm_pc = 16'h0200;
        emit(f_movl(4'd9, 8'h00));  emit(f_movh(4'd9, 8'h10));
        emit(f_movl(4'd10, 8'hFE));
        emit(f_movl(4'd1, 8'h85));  emit(f_st(4'd9, 4'd1));  exp_st(15'h0800, 16'hFF85); bump_r9();
        emit(f_movh(4'd1, 8'h12));  emit(f_st(4'd9, 4'd1));  exp_st(15'h0801, 16'h1285); bump_r9();
        emit(f_movl(4'd2, 8'h05));  emit(f_movl(4'd3, 8'h07));
        emit(f_sub(4'd2, 4'd3, 4'd4));
        emit(f_st(4'd9, 4'd4));     exp_st(15'h0802, 16'hFFFE); bump_r9();
        emit(f_sub(4'd3, 4'd0, 4'd0));
        emit(f_st(4'd9, 4'd0));     exp_st(15'h0803, 16'h0000); bump_r9();
        emit(f_movl(4'd5, 8'h10));
        emit(f_ld(4'd5, 4'd6));     rd_q.push_back(16'h8008);
        emit(f_st(4'd9, 4'd6));     exp_st(15'h0804, 16'hBEEF); bump_r9();
        emit(f_st(4'd5, 4'd6));     exp_st(15'h0008, 16'hBEEF);
        emit(f_movl(4'd7, 8'h40));
        emit(f_jmp(4'd0, 4'h0, 4'd7));
        emit(f_movl(4'd15, 8'h11)); emit(f_st(4'd9, 4'd15));

        asm_pc = 16'h0040;
        emit(f_movl(4'd8, 8'h5A));  emit(f_st(4'd9, 4'd8));  exp_st(15'h0805, 16'h005A); bump_r9();
        emit(f_jmp(4'd0, 4'h1, 4'd7));
        emit(f_st(4'd9, 4'd8));     exp_st(15'h0806, 16'h005A); bump_r9();
        emit(f_movl(4'd12, 8'h00)); emit(f_movh(4'd12, 8'h80));
        emit(f_movl(4'd13, 8'h60));
        emit(f_jmp(4'd12, 4'h2, 4'd13));
        emit(f_movl(4'd15, 8'h22)); emit(f_st(4'd9, 4'd15));

        asm_pc = 16'h0060;
        emit(f_st(4'd9, 4'd12));    exp_st(15'h0807, 16'h8000); bump_r9();
        emit(16'hD003);             pr_q.push_back(3'b111);
        p_addr = asm_pc;
        emit(f_movl(4'd14, 8'h33)); emit(f_st(4'd9, 4'd14)); exp_st(15'h0808, 16'h0033); bump_r9();
        q_addr = asm_pc;
        emit(f_movl(4'd14, 8'h44)); emit(f_st(4'd9, 4'd14)); exp_st(15'h0809, 16'h0044); bump_r9();
        h_addr = asm_pc;
        emit(16'hA000);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", 32'(pc), 32'h0200);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_wen", 32'(wen), 32'd0);
        chk("rst_raddr1", 32'(raddr1), 32'd0);
        chk("rst_pr", 32'(pauseResume), 32'd0);
        chk("rst_wbus", {1'b0, waddr, wdata}, 32'd0);
        reset = 1'b0;

        // One-cycle stall request during DECODE of the instruction at p_addr
        wait_pc(p_addr, "reach_stall_pc");
        n = 1;
        @(negedge clk);
        stall_num = 3'd3;
        if (pc == p_addr) n++;
        @(negedge clk);
        stall_num = 3'd0;
        for (int k = 0; k < 20 && pc == p_addr; k++) begin
            n++;
            @(negedge clk);
        end
        chk("stall_cycles", 32'(n), 32'd6);

        // Held stall request models a paused core
        wait_pc(q_addr, "reach_pause_pc");
        stall_num = 3'd6;
        moved = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (pc != q_addr) moved = 1'b1;
        end
        chk("paused_hold", 32'(moved), 32'd0);
        chk("paused_pc", 32'(pc), 32'(q_addr));
        stall_num = 3'd0;

        n = 0;
        while (!halt && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("halt_seen", 32'(halt), 32'd1);
        chk("halt_pc", 32'(pc), 32'(h_addr));
        bad = 1'b0;
        repeat (12) begin
            stall_num = 3'($urandom_range(0, 7));
            @(negedge clk);
            if (!halt || wen || raddr1 != 16'h0 || pauseResume != 3'b0 || pc != h_addr) bad = 1'b1;
        end
        chk("halted_idle", 32'(bad), 32'd0);
        chk("st_q_drained", 32'(st_q.size()), 32'd0);
        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
        chk("pr_q_drained", 32'(pr_q.size()), 32'd0);

        // Reset from HALTED restarts at the new start address, bit 16 ignored
        reset     = 1'b1;
        pc_passed = 17'h1_0040;
        stall_num = 3'd5;
        @(negedge clk);
        chk("rerst_pc", 32'(pc), 32'h0040);
        chk("rerst_halt", 32'(halt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
